// File: rtl/id_ex_buffer_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_buffer_pkg
// Shared pipeline definitions: the decoded control bundle carried between
// stages and the all-zero bubble value used when a stage is killed.
// Also used by the decoder and the other stage buffers.
// ---------------------------------------------------------------------------
package id_ex_buffer_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       MemtoReg;
        logic       ALUSrc;
        logic       Branch;
        logic       Jump;
        logic [3:0] ALUop;
        logic [2:0] funct3;
    } ctrl_t;

    // A bubble must never write a register, touch memory or redirect fetch.
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_buffer_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at its maximum value instead of wrapping.
// Ports:
//   clk    - counting clock, rising edge
//   rst    - asynchronous, active-high clear
//   inc    - count one event on this edge
//   clear  - synchronous clear (wins over inc)
//   count  - current value, WIDTH bits
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_buffer.sv
// ---------------------------------------------------------------------------
// id_ex_buffer
// ID -> EX pipeline register with bubble insertion and event counters.
// Ports:
//   i_clk, i_rst         - pipeline clock, asynchronous active-high reset
//   NOP                  - load-use stall: put a bubble into EX
//   flush                - redirect resolved in EX: kill the instruction in ID
//   valid_ID, *_ID       - decoded instruction from ID
//   valid_EX, *_EX       - registered copies presented to EX
//   MemRead_EX           - ctrl_EX.MemRead, for hazard detection
//   bubble_cnt,flush_cnt - saturating counts of stall bubbles / flushes
// Per edge: flush beats NOP beats a normal load.
// ---------------------------------------------------------------------------
module id_ex_buffer
    import id_ex_buffer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             NOP,
    input  logic             flush,
    input  logic             valid_ID,
    input  logic [31:0]      pc_ID,
    input  logic [31:0]      rs1_data_ID,
    input  logic [31:0]      rs2_data_ID,
    input  logic [31:0]      imm_ID,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic [4:0]       rd_ID,
    input  ctrl_t            ctrl_ID,
    output logic             valid_EX,
    output logic [31:0]      pc_EX,
    output logic [31:0]      rs1_data_EX,
    output logic [31:0]      rs2_data_EX,
    output logic [31:0]      imm_EX,
    output logic [4:0]       rs1_EX,
    output logic [4:0]       rs2_EX,
    output logic [4:0]       rd_EX,
    output ctrl_t            ctrl_EX,
    output logic             MemRead_EX,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic kill;
    assign kill = flush | NOP;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_EX    <= 1'b0;
            pc_EX       <= '0;
            rs1_data_EX <= '0;
            rs2_data_EX <= '0;
            imm_EX      <= '0;
            rs1_EX      <= '0;
            rs2_EX      <= '0;
            rd_EX       <= '0;
            ctrl_EX     <= CTRL_NOP;
        end else if (kill) begin
            valid_EX    <= 1'b0;
            pc_EX       <= '0;
            rs1_data_EX <= '0;
            rs2_data_EX <= '0;
            imm_EX      <= '0;
            rs1_EX      <= '0;
            rs2_EX      <= '0;
            rd_EX       <= '0;
            ctrl_EX     <= CTRL_NOP;
        end else begin
            valid_EX    <= valid_ID;
            pc_EX       <= pc_ID;
            rs1_data_EX <= rs1_data_ID;
            rs2_data_EX <= rs2_data_ID;
            imm_EX      <= imm_ID;
            rs1_EX      <= rs1_ID;
            rs2_EX      <= rs2_ID;
            // An invalid slot keeps its data but must not look like a
            // producer to forwarding or write anything downstream.
            rd_EX       <= valid_ID ? rd_ID   : 5'd0;
            ctrl_EX     <= valid_ID ? ctrl_ID : CTRL_NOP;
        end
    end

    assign MemRead_EX = ctrl_EX.MemRead;

    // Simultaneous NOP and flush counts only as a flush.
    sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .inc   (NOP & ~flush),
        .clear (1'b0),
        .count (bubble_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .inc   (flush),
        .clear (1'b0),
        .count (flush_cnt)
    );

endmodule
